// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: register map, CTRL field layout and address decode positions for counter_bank
package counter_bank_pkg;
  // Register index is byte offset within a channel divided by 4
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_COUNT  = 2'd1,
    REG_RELOAD = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_DIR     = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int PRESC_LSB    = 8;
  localparam int PRESC_MSB    = 15;
  localparam int STATUS_MATCH = 0;
  localparam int ADR_REG_LSB  = 2;
  localparam int ADR_REG_MSB  = 3;
  localparam int ADR_CH_LSB   = 4;
  localparam int ADR_CH_MSB   = 6;
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/counter_bank_channel.sv
// counter_bank_channel: one counter channel with prescaler, up/down step, one-shot, sticky match and irq
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  reg_e            reg_sel,
  input  logic [31:0]     wr_data,
  input  logic [3:0]      wr_sel,
  output logic [31:0]     rdata,
  output logic [BITS-1:0] count,
  output logic            tick,
  output logic            irq
);
  logic en, dir, oneshot, irq_en, match;
  logic [7:0] presc, pcnt;
  logic [BITS-1:0] reload, count_nxt, count_w, reload_w;
  logic [31:0] m;
  logic ctrl_wr, count_wr, reload_wr, status_clr, step, wrap, match_ev;
  logic unused_wr;
  assign unused_wr = ^{wr_data, m};
  always_comb begin
    m = sel_mask(wr_sel);
    ctrl_wr = wr && reg_sel == REG_CTRL;
    count_wr = wr && reg_sel == REG_COUNT;
    reload_wr = wr && reg_sel == REG_RELOAD;
    status_clr = wr && reg_sel == REG_STATUS && wr_sel[0] && wr_data[STATUS_MATCH];
    // Any CTRL write restarts the prescaler and suppresses a coinciding step
    step = en && pcnt == presc && !ctrl_wr;
    wrap = dir ? count == '0 : count == reload;
    match_ev = step && wrap && !count_wr;
    count_nxt = wrap ? (dir ? reload : '0) : (dir ? count - BITS'(1) : count + BITS'(1));
    count_w = (count & ~m[BITS-1:0]) | (wr_data[BITS-1:0] & m[BITS-1:0]);
    reload_w = (reload & ~m[BITS-1:0]) | (wr_data[BITS-1:0] & m[BITS-1:0]);
    rdata = reg_sel == REG_CTRL ? {16'b0, presc, 4'b0, irq_en, oneshot, dir, en} :
            reg_sel == REG_COUNT ? 32'(count) :
            reg_sel == REG_RELOAD ? 32'(reload) : {31'b0, match};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= 1'b0;
      dir <= 1'b0;
      oneshot <= 1'b0;
      irq_en <= 1'b0;
      presc <= '0;
      pcnt <= '0;
      count <= '0;
      reload <= '0;
      match <= 1'b0;
      tick <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        if (wr_sel[0]) begin
          en <= wr_data[CTRL_EN];
          dir <= wr_data[CTRL_DIR];
          oneshot <= wr_data[CTRL_ONESHOT];
          irq_en <= wr_data[CTRL_IRQ_EN];
        end
        if (wr_sel[1]) presc <= wr_data[PRESC_MSB:PRESC_LSB];
      end else if (match_ev && oneshot) en <= 1'b0;
      pcnt <= (!en || ctrl_wr || step) ? '0 : pcnt + 8'd1;
      if (count_wr) count <= count_w;
      else if (step) count <= count_nxt;
      if (reload_wr) reload <= reload_w;
      // A new match wins over a coinciding write-1-to-clear
      match <= match_ev || (match && !status_clr);
      tick <= match_ev;
      irq <= match && irq_en;
    end
  end
endmodule

// File: rtl/counter_bank.sv
// counter_bank: Wishbone-mapped bank of CHANNELS programmable counter/timer channels
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int BITS     = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [CHANNELS*BITS-1:0] cnt_o,
  output logic [CHANNELS-1:0]      tick_o,
  output logic [CHANNELS-1:0]      irq_o
);
  logic access, hit;
  logic [2:0] ch;
  reg_e reg_sel;
  logic [31:0] rd;
  logic [31:0] ch_rd [CHANNELS];
  logic unused_adr;
  assign ch = wbs_adr_i[ADR_CH_MSB:ADR_CH_LSB];
  assign reg_sel = reg_e'(wbs_adr_i[ADR_REG_MSB:ADR_REG_LSB]);
  assign hit = int'(ch) < CHANNELS;
  assign access = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign unused_adr = ^{wbs_adr_i[31:ADR_CH_MSB+1], wbs_adr_i[ADR_REG_LSB-1:0]};
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    counter_bank_channel #(.BITS(BITS)) u_ch (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_ni),
      .wr     (access && wbs_we_i && hit && ch == 3'(i)),
      .reg_sel(reg_sel),
      .wr_data(wbs_dat_i),
      .wr_sel (wbs_sel_i),
      .rdata  (ch_rd[i]),
      .count  (cnt_o[i*BITS +: BITS]),
      .tick   (tick_o[i]),
      .irq    (irq_o[i])
    );
  end
  always_comb begin
    rd = '0;
    for (int k = 0; k < CHANNELS; k++) if (hit && ch == 3'(k)) rd = ch_rd[k];
  end
  // Writes commit on the same edge that raises ack; read data is captured there too
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd : '0;
    end
  end
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: scoreboard bench for counter_bank register access and counting behaviour
module tb_counter_bank;
  logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat = 0, dat_o;
  logic ack;
  logic [63:0] cnt_o;
  logic [3:0] tick_o, irq_o;
  int checks = 0, fails = 0;
  logic rd_q[$];
  logic [31:0] exp_q[$];
  string tag_q[$];
  logic mon_rd;
  logic [31:0] mon_exp;
  string mon_tag;

  counter_bank #(.CHANNELS(4), .BITS(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .cnt_o(cnt_o), .tick_o(tick_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] a(input int c, input int r);
    return 32'(c * 16 + r * 4);
  endfunction

  function automatic logic [31:0] cnt(input int c);
    return 32'(cnt_o[c*16 +: 16]);
  endfunction

  always @(negedge clk) if (ack) begin
    if (rd_q.size() == 0) check("spurious_ack", 1, 0);
    else begin
      mon_rd = rd_q.pop_front();
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      if (mon_rd) check(mon_tag, dat_o, mon_exp);
    end
  end

  // Caller is 1ns after a rising edge; returns 1ns after the edge following the ack edge
  task automatic xfer(input logic w, input logic [31:0] ad, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e, input string t);
    bit got = 0;
    cyc = 1; stb = 1; we = w; adr = ad; dat = d; sel = s;
    rd_q.push_back(!w); exp_q.push_back(e); tag_q.push_back(t);
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) begin
      check({t, "_ack_timeout"}, 0, 1);
      void'(rd_q.pop_back()); void'(exp_q.pop_back()); void'(tag_q.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s = 4'hF);
    xfer(1, ad, d, s, 0, "wr");
  endtask

  task automatic rd(input logic [31:0] ad, input logic [31:0] e, input string t);
    xfer(0, ad, 0, 4'hF, e, t);
  endtask

  initial begin
    #12;
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", dat_o, 0);
    check("rst_cnt_lo", cnt_o[31:0], 0);
    check("rst_cnt_hi", cnt_o[63:32], 0);
    check("rst_tick", 32'(tick_o), 0);
    check("rst_irq", 32'(irq_o), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // ch0 up count with RELOAD=5
    wr(a(0, 2), 5);
    wr(a(0, 0), 32'h1);
    for (int k = 1; k <= 7; k++) begin
      check("t1_cnt", cnt(0), 32'(k % 6));
      check("t1_tick", 32'(tick_o[0]), 32'(k == 6));
      @(posedge clk); #1;
    end
    wr(a(0, 0), 0);
    rd(a(0, 3), 1, "t1_status");
    rd(a(0, 1), 2, "t1_count_stopped");

    // ch1 down, one-shot, PRESC=3
    wr(a(1, 2), 3);
    wr(a(1, 1), 3);
    wr(a(1, 0), 32'h0307);
    for (int k = 1; k <= 20; k++) begin
      check("t2_cnt", cnt(1), k < 4 ? 3 : k < 8 ? 2 : k < 12 ? 1 : k < 16 ? 0 : 3);
      check("t2_tick", 32'(tick_o[1]), 32'(k == 16));
      @(posedge clk); #1;
    end
    rd(a(1, 0), 32'h0306, "t2_ctrl_en_cleared");
    rd(a(1, 1), 3, "t2_count");
    rd(a(1, 3), 1, "t2_status");

    // ch2 irq, W1C races, EN-clear suppression
    wr(a(2, 2), 2);
    wr(a(2, 0), 32'h9);
    for (int k = 1; k <= 4; k++) begin
      check("t3_tick", 32'(tick_o[2]), 32'(k == 3));
      check("t3_irq", 32'(irq_o[2]), 32'(k == 4));
      @(posedge clk); #1;
    end
    wr(a(2, 3), 1);
    rd(a(2, 3), 1, "t3_w1c_vs_match");
    wr(a(2, 3), 1);
    check("t3_irq_cleared", 32'(irq_o[2]), 0);
    wr(a(2, 0), 0);
    rd(a(2, 3), 0, "t3_step_suppressed_status");
    rd(a(2, 1), 2, "t3_step_suppressed_count");

    // ch3 byte write of COUNT beating a matching step
    wr(a(3, 2), 32'hAB00);
    wr(a(3, 1), 32'hAAFE);
    wr(a(3, 0), 32'h1);
    @(posedge clk); #1;
    wr(a(3, 1), 32'h1234, 4'b0001);
    check("t4_cnt", cnt(3), 32'hAB35);
    rd(a(3, 3), 0, "t4_no_match");
    wr(a(3, 0), 0);

    // unmapped channel 7
    wr(a(7, 0), 32'hFFFF_FFFF);
    rd(a(7, 0), 0, "t5_ch7_ctrl");
    rd(a(7, 1), 0, "t5_ch7_count");
    check("t5_cnt_lo", cnt_o[31:0], 32'h0003_0002);
    check("t5_cnt_hi", cnt_o[63:32], 32'hAB37_0002);

    // held cyc/stb: one access every other cycle
    cyc = 1; stb = 1; we = 0; adr = a(0, 1);
    for (int j = 0; j < 3; j++) begin
      rd_q.push_back(1); exp_q.push_back(2); tag_q.push_back("t5_held_rd");
    end
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      check("t5_held_ack", 32'(ack), 32'(j % 2));
    end
    cyc = 0; stb = 0;
    @(posedge clk); #1;

    // reset while ack is high, then while a write is pending
    wr(a(0, 0), 1);
    cyc = 1; stb = 1; we = 0; adr = a(0, 0);
    @(posedge clk); #1;
    check("t6_pre_ack", 32'(ack), 1);
    rst_n = 0;
    #1;
    check("t6_ack", 32'(ack), 0);
    check("t6_dat", dat_o, 0);
    check("t6_cnt_lo", cnt_o[31:0], 0);
    check("t6_cnt_hi", cnt_o[63:32], 0);
    check("t6_tick_irq", {tick_o, irq_o}, 0);
    we = 1; adr = a(0, 2); dat = 32'h77;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    #1 rst_n = 1;
    @(posedge clk); #1;
    rd(a(0, 2), 0, "t6_reload_not_written");
    rd(a(0, 0), 0, "t6_ctrl_reset");
    check("t6_cnt_idle", cnt_o[31:0], 0);

    check("sb_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/counter_bank.md
# counter_bank

Multi-channel programmable counter/timer on the Caravel Wishbone slave port; successor to the single free-running counter in the user project area. Instantiates CHANNELS independent BITS-wide counters, each with up/down mode, reload/compare value, 8-bit prescaler, one-shot mode, sticky match flag and maskable interrupt. Sits directly under the user project wrapper and drives the user IRQ lines and GPIO count view.

## Interface
- CHANNELS, 4, number of counter channels (1..8)
- BITS, 16, counter width per channel (1..32)
- wb_clk_i  in  1  clock, all state on rising edge
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address; [6:4] channel, [3:2] register
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- cnt_o  out  CHANNELS*BITS  live counter values, channel 0 in LSBs
- tick_o  out  CHANNELS  one-cycle pulse on each channel match event
- irq_o  out  CHANNELS  level interrupt = MATCH & IRQ_EN, registered

## Operation
- Registers per channel (offset within channel): 0x0 CTRL, 0x4 COUNT, 0x8 RELOAD, 0xC STATUS.
- CTRL: [0] EN, [1] DIR (0 up, 1 down), [2] ONESHOT, [3] IRQ_EN, [15:8] PRESC; other bits read 0.
- COUNT/RELOAD: BITS wide, zero-extended on read, upper write bits ignored. STATUS: [0] MATCH, sticky, write-1-to-clear.
- Prescaler: while EN, 8-bit prescale counter increments each cycle; count step ("tick") occurs when it equals PRESC, then it returns to 0. PRESC=0 → step every cycle. Prescale counter cleared when EN=0 and on any CTRL write.
- Up mode step: if COUNT==RELOAD → COUNT<=0, match event; else COUNT+1.
- Down mode step: if COUNT==0 → COUNT<=RELOAD, match event; else COUNT-1.
- Match event: MATCH<=1, tick_o pulses; if ONESHOT, EN<=0 in the same edge (COUNT still wraps/reloads).
- Arithmetic modulo 2^BITS; RELOAD=0 in up mode gives a match every step.
- Byte-select writes: only selected bytes of a register update.
- Channel index ≥ CHANNELS or unmapped bits: read 0, ack normally, writes ignored.

## Timing
- Reset: all registers 0, wbs_ack_o=0, wbs_dat_o=0, cnt_o=0, tick_o=0, irq_o=0; prescalers 0.
- Handshake: access when cyc&stb&!ack; ack asserted next cycle for exactly one cycle; wbs_dat_o captured on the same edge. Held cyc&stb yields one access every 2 cycles.
- Register write takes effect on the ack edge; first step with new CTRL no earlier than PRESC+1 cycles later.
- COUNT write beats a simultaneous step (written value wins, no match generated that cycle).
- MATCH W1C in the same cycle as a new match event: set wins, MATCH stays 1.
- CTRL write clearing EN in the cycle of a step: step suppressed.
- irq_o lags MATCH/IRQ_EN by one cycle; tick_o is aligned with the edge updating MATCH.
- Reset assertion mid-transaction: ack dropped immediately, no write committed after the reset edge.

## Structure
- Package counter_bank_pkg: register offsets, CTRL bit positions and PRESC field range, address field positions.
- Sub-module counter_bank_channel: one channel's CTRL/COUNT/RELOAD/MATCH state, prescaler, step logic, tick and irq; top holds Wishbone decode, ack, read mux and generate loop.

## Test plan
- Reset, ch0 RELOAD=5, CTRL=0x1 (up, PRESC=0) → COUNT reads 0,1..5,0; tick_o[0] pulse on the 5→0 edge; STATUS=1.
- ch1 RELOAD=3, COUNT=3, CTRL=0x0307 (down, one-shot, PRESC=3) → step every 4 cycles 3,2,1,0,3 then EN reads 0, COUNT stays 3.
- ch2 IRQ_EN+EN, RELOAD=2 → irq_o[2] rises one cycle after match; write STATUS=1 → irq_o clears; W1C coinciding with match → MATCH stays 1.
- Write COUNT=0x1234 with sel=0b0001 while running → low byte 0x34 loaded, written value overrides step that cycle, no tick.
- Access channel 7 with CHANNELS=4 → ack after 1 cycle, read 0, no state change; held cyc/stb → ack every other cycle.
- Assert wb_rst_ni low mid-count and mid-write → all outputs 0 immediately, write not committed.
